excp_flush_ctrl: RTL and testbench
==================================

EXCP_FLUSH_CTRL -- requirements
Module: excp_flush_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter DBG_ENTRY_ADDR, default 32'h0000_0800, debug-mode entry PC.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port dbg_req, input, 1, ebreak-to-debug flush request (level, held until accepted).
REQ-006 SHALL have port excp_req, input, 1, synchronous exception flush request (level).
REQ-007 SHALL have port excp_cause, input, XLEN, exception cause code.
REQ-008 SHALL have port excp_pc / excp_tval, input, XLEN each, faulting PC and trap value.
REQ-009 SHALL have port irq_req, input, 1, pending interrupt; irq_cause, input, 4, interrupt number.
REQ-010 SHALL have port mret_req, input, 1, mret commit request.
REQ-011 SHALL have port mie_r, input, 1, global interrupt enable; mtvec_r / mepc_r, input, XLEN each.
REQ-012 SHALL have port excp_ready, output, 1, controller can accept a request this cycle.
REQ-013 SHALL have port flush_req, output, 1, and flush_pc, output, XLEN, IFU flush request and target.
REQ-014 SHALL have port flush_ack, input, 1, IFU accepts flush.
REQ-015 SHALL have ports csr_mepc_we, csr_mcause_we, csr_mtval_we, csr_dpc_we, dbg_mode_set, mstatus_trap, mstatus_mret, output, 1 each, single-cycle update strobes.
REQ-016 SHALL have ports csr_epc_wdata, csr_mcause_wdata, csr_mtval_wdata, output, XLEN each.
REQ-017 SHALL have port trap_cnt, output, 16, count of completed traps (exception+interrupt).

Function
REQ-018 SHALL implement states IDLE, FLUSH, UPDATE; excp_ready = (state==IDLE).
REQ-019 In IDLE, accept highest-priority valid request: dbg_req > excp_req > (irq_req & mie_r) > mret_req; lower requests ignored that cycle.
REQ-020 On accept, SHALL register kind, cause, pc, tval and flush target, then go to FLUSH next cycle; no request -> stay IDLE.
REQ-021 Flush target: dbg -> DBG_ENTRY_ADDR; excp -> {mtvec_r[XLEN-1:2],2'b00}; irq -> same base if mtvec_r[0]==0, else base + 4*irq_cause; mret -> mepc_r; addition wraps modulo 2^XLEN.
REQ-022 flush_req SHALL be 1 exactly in FLUSH; flush_pc SHALL be stable for the whole FLUSH state; flush_pc = 0 outside FLUSH.
REQ-023 In FLUSH, flush_ack==1 -> UPDATE next cycle; otherwise remain in FLUSH indefinitely; flush_ack outside FLUSH ignored.
REQ-024 UPDATE lasts exactly one cycle then returns to IDLE; strobes of REQ-015 SHALL be high only in UPDATE.
REQ-025 UPDATE for excp: csr_mepc_we, csr_mcause_we, csr_mtval_we, mstatus_trap = 1; wdata = captured excp_pc, excp_cause, excp_tval.
REQ-026 UPDATE for irq: csr_mepc_we, csr_mcause_we, csr_mtval_we, mstatus_trap = 1; mcause_wdata = {1'b1, zeros, irq_cause}; epc_wdata = excp_pc captured at accept; mtval_wdata = 0.
REQ-027 UPDATE for dbg: csr_dpc_we, dbg_mode_set = 1; epc_wdata = captured excp_pc; no M-mode CSR strobes.
REQ-028 UPDATE for mret: mstatus_mret = 1 only.
REQ-029 wdata outputs SHALL be 0 when not in UPDATE.
REQ-030 trap_cnt increments by 1 in UPDATE for excp or irq, saturates at 16'hFFFF, unchanged for dbg/mret.
REQ-031 Requests arriving while not IDLE SHALL not be captured; requesters hold them; minimum accept-to-accept spacing is 3 cycles (ack in first FLUSH cycle).

Reset
REQ-032 With rst_n==0 at a rising edge, state -> IDLE, captured registers and trap_cnt -> 0, regardless of current state (including mid-FLUSH without ack).
REQ-033 During and after reset: excp_ready=1, flush_req=0, flush_pc=0, all strobes 0, all wdata 0, trap_cnt=0.

Verification
REQ-034 excp_req, cause=2, pc=0x100, tval=0xDEAD, mtvec_r=0x200, ack 2 cycles after flush_req -> flush_pc=0x200 held 3 cycles; UPDATE: mepc=0x100, mcause=2, mtval=0xDEAD, trap_cnt=1.
REQ-035 dbg_req, excp_req, irq_req, mret_req all high in IDLE -> dbg taken; flush_pc=0x800; dbg_mode_set, csr_dpc_we pulse; trap_cnt unchanged.
REQ-036 irq_req, mie_r=1, irq_cause=7, mtvec_r=0x301 -> flush_pc=0x31C; mcause_wdata=0x8000_0007; with mie_r=0 -> no accept, excp_ready stays 1.
REQ-037 mret_req, mepc_r=0x480, immediate ack -> flush_pc=0x480; mstatus_mret pulses one cycle; back in IDLE 3 cycles after accept.
REQ-038 rst_n low in FLUSH with flush_ack=0 -> next cycle flush_req=0, IDLE, no strobes; trap_cnt forced to 16'hFFFF-path test: 65536 traps -> stays 16'hFFFF.

Source files
------------

// File: rtl/excp_flush_if.sv
// excp_flush_if: request, IFU-flush and CSR-update signals of the trap flush
// controller. The master side is the pipeline/IFU/CSR environment, the slave
// side is the controller itself.
interface excp_flush_if #(
    parameter int XLEN = 32
);
    // Requests from the pipeline
    logic            dbg_req;
    logic            excp_req;
    logic [XLEN-1:0] excp_cause;
    logic [XLEN-1:0] excp_pc;
    logic [XLEN-1:0] excp_tval;
    logic            irq_req;
    logic [3:0]      irq_cause;
    logic            mret_req;

    // Current CSR state
    logic            mie_r;
    logic [XLEN-1:0] mtvec_r;
    logic [XLEN-1:0] mepc_r;

    // Acceptance and IFU flush handshake
    logic            excp_ready;
    logic            flush_req;
    logic [XLEN-1:0] flush_pc;
    logic            flush_ack;

    // CSR update strobes and write data
    logic            csr_mepc_we;
    logic            csr_mcause_we;
    logic            csr_mtval_we;
    logic            csr_dpc_we;
    logic            dbg_mode_set;
    logic            mstatus_trap;
    logic            mstatus_mret;
    logic [XLEN-1:0] csr_epc_wdata;
    logic [XLEN-1:0] csr_mcause_wdata;
    logic [XLEN-1:0] csr_mtval_wdata;
    logic [15:0]     trap_cnt;

    modport master (
        output dbg_req, excp_req, excp_cause, excp_pc, excp_tval,
               irq_req, irq_cause, mret_req, mie_r, mtvec_r, mepc_r, flush_ack,
        input  excp_ready, flush_req, flush_pc,
               csr_mepc_we, csr_mcause_we, csr_mtval_we, csr_dpc_we,
               dbg_mode_set, mstatus_trap, mstatus_mret,
               csr_epc_wdata, csr_mcause_wdata, csr_mtval_wdata, trap_cnt
    );

    modport slave (
        input  dbg_req, excp_req, excp_cause, excp_pc, excp_tval,
               irq_req, irq_cause, mret_req, mie_r, mtvec_r, mepc_r, flush_ack,
        output excp_ready, flush_req, flush_pc,
               csr_mepc_we, csr_mcause_we, csr_mtval_we, csr_dpc_we,
               dbg_mode_set, mstatus_trap, mstatus_mret,
               csr_epc_wdata, csr_mcause_wdata, csr_mtval_wdata, trap_cnt
    );
endinterface

// File: rtl/excp_flush_ctrl.sv
// excp_flush_ctrl: sequences debug entry, exceptions, interrupts and mret.
// IDLE accepts the highest-priority request, FLUSH holds the IFU redirect
// until it is acknowledged, UPDATE pulses the CSR write strobes for a cycle.
// All outputs are registered.
module excp_flush_ctrl #(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] DBG_ENTRY_ADDR = 'h0000_0800
) (
    input  logic        clk,
    input  logic        rst_n,
    excp_flush_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FLUSH, UPDATE} state_t;
    typedef enum logic [1:0] {KIND_DBG, KIND_EXCP, KIND_IRQ, KIND_MRET} kind_t;

    state_t          state;
    kind_t           kind_q;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] tval_q;
    logic [15:0]     trap_cnt_q;

    logic            acc_valid;
    kind_t           acc_kind;
    logic [XLEN-1:0] acc_cause;
    logic [XLEN-1:0] acc_pc;
    logic [XLEN-1:0] acc_tval;
    logic [XLEN-1:0] acc_target;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] irq_offset;

    // mtvec with the two mode bits cleared; vectored interrupts add 4*cause.
    assign trap_base  = bus.mtvec_r & ~{{(XLEN-2){1'b0}}, 2'b11};
    assign irq_offset = {{(XLEN-6){1'b0}}, bus.irq_cause, 2'b00};

    assign bus.trap_cnt = trap_cnt_q;

    // Priority pick of the request to accept and what to capture for it.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        acc_valid  = 1'b1;
        acc_kind   = KIND_DBG;
        acc_cause  = '0;
        acc_pc     = bus.excp_pc;
        acc_tval   = '0;
        acc_target = DBG_ENTRY_ADDR;
        if (bus.dbg_req) begin
            acc_kind = KIND_DBG;
        end else if (bus.excp_req) begin
            acc_kind   = KIND_EXCP;
            acc_cause  = bus.excp_cause;
            acc_tval   = bus.excp_tval;
            acc_target = trap_base;
        end else if (bus.irq_req && bus.mie_r) begin
            acc_kind   = KIND_IRQ;
            acc_cause  = {1'b1, {(XLEN-5){1'b0}}, bus.irq_cause};
            acc_target = bus.mtvec_r[0] ? trap_base + irq_offset : trap_base;
        end else if (bus.mret_req) begin
            acc_kind   = KIND_MRET;
            acc_pc     = '0;
            acc_target = bus.mepc_r;
        end else begin
            acc_valid = 1'b0;
        end
    end

    // Controller FSM with registered flush, strobe, wdata and counter outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state                <= IDLE;
            kind_q               <= KIND_DBG;
            cause_q              <= '0;
            pc_q                 <= '0;
            tval_q               <= '0;
            trap_cnt_q           <= '0;
            bus.excp_ready       <= 1'b1;
            bus.flush_req        <= 1'b0;
            bus.flush_pc         <= '0;
            bus.csr_mepc_we      <= 1'b0;
            bus.csr_mcause_we    <= 1'b0;
            bus.csr_mtval_we     <= 1'b0;
            bus.csr_dpc_we       <= 1'b0;
            bus.dbg_mode_set     <= 1'b0;
            bus.mstatus_trap     <= 1'b0;
            bus.mstatus_mret     <= 1'b0;
            bus.csr_epc_wdata    <= '0;
            bus.csr_mcause_wdata <= '0;
            bus.csr_mtval_wdata  <= '0;
        end else begin
            // Strobes and write data are single-cycle pulses unless set below.
            bus.csr_mepc_we      <= 1'b0;
            bus.csr_mcause_we    <= 1'b0;
            bus.csr_mtval_we     <= 1'b0;
            bus.csr_dpc_we       <= 1'b0;
            bus.dbg_mode_set     <= 1'b0;
            bus.mstatus_trap     <= 1'b0;
            bus.mstatus_mret     <= 1'b0;
            bus.csr_epc_wdata    <= '0;
            bus.csr_mcause_wdata <= '0;
            bus.csr_mtval_wdata  <= '0;
            case (state)
                IDLE: begin
                    if (acc_valid) begin
                        state          <= FLUSH;
                        kind_q         <= acc_kind;
                        cause_q        <= acc_cause;
                        pc_q           <= acc_pc;
                        tval_q         <= acc_tval;
                        bus.excp_ready <= 1'b0;
                        bus.flush_req  <= 1'b1;
                        bus.flush_pc   <= acc_target;
                    end
                end
                FLUSH: begin
                    if (bus.flush_ack) begin
                        state                <= UPDATE;
                        bus.flush_req        <= 1'b0;
                        bus.flush_pc         <= '0;
                        bus.csr_epc_wdata    <= pc_q;
                        bus.csr_mcause_wdata <= cause_q;
                        bus.csr_mtval_wdata  <= tval_q;
                        case (kind_q)
                            KIND_EXCP, KIND_IRQ: begin
                                bus.csr_mepc_we   <= 1'b1;
                                bus.csr_mcause_we <= 1'b1;
                                bus.csr_mtval_we  <= 1'b1;
                                bus.mstatus_trap  <= 1'b1;
                                // Saturating count, visible during UPDATE.
                                if (trap_cnt_q != 16'hFFFF) begin
                                    trap_cnt_q <= trap_cnt_q + 16'd1;
                                end
                            end
                            KIND_DBG: begin
                                bus.csr_dpc_we   <= 1'b1;
                                bus.dbg_mode_set <= 1'b1;
                            end
                            default: begin
                                bus.mstatus_mret <= 1'b1;
                            end
                        endcase
                    end
                end
                UPDATE: begin
                    state          <= IDLE;
                    bus.excp_ready <= 1'b1;
                end
                default: begin
                    state          <= IDLE;
                    bus.excp_ready <= 1'b1;
                    bus.flush_req  <= 1'b0;
                    bus.flush_pc   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_excp_flush_ctrl.sv
// tb_excp_flush_ctrl: table of request vectors with expected flush target and
// CSR update, a scoreboard queue checked by a negedge monitor, plus hand
// sequences for masking, back-to-back spacing, reset mid-flush, saturation.
module tb_excp_flush_ctrl;
    localparam logic [6:0] S_TRAP = 7'b1110010;
    localparam logic [6:0] S_DBG  = 7'b0001100;
    localparam logic [6:0] S_MRET = 7'b0000001;

    typedef struct {
        logic        dbg, excp, irq, mie, mret;
        logic [31:0] cause, pc, tval;
        logic [3:0]  irqc;
        logic [31:0] mtvec, mepc;
        int          dly;
        logic [31:0] fpc;
        logic [6:0]  strb;
        logic [31:0] epc, mcause, mtval;
    } vec_t;

    typedef struct {
        logic [31:0] fpc;
        logic [6:0]  strb;
        logic [31:0] epc, mcause, mtval;
        logic [15:0] cnt;
        int          flen;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n;
    int     n_vec = 0;
    int     n_fail = 0;
    int     cyc = 0;
    int     flush_len = 0;
    bit     mon_en = 1'b0;
    logic [15:0] exp_cnt;
    logic [15:0] mon_cnt;
    exp_t   exp_q[$];
    exp_t   mon_e;
    vec_t   vecs[10];
    logic [6:0] strb;

    excp_flush_if #(.XLEN(32)) bus ();

    excp_flush_ctrl #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign strb = {bus.csr_mepc_we, bus.csr_mcause_we, bus.csr_mtval_we, bus.csr_dpc_we,
                   bus.dbg_mode_set, bus.mstatus_trap, bus.mstatus_mret};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drop_reqs();
        bus.dbg_req  = 1'b0;
        bus.excp_req = 1'b0;
        bus.irq_req  = 1'b0;
        bus.mret_req = 1'b0;
    endtask

    // Monitor: flush target while flushing, CSR update on UPDATE, quiet otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.flush_req) begin
                if (exp_q.size() == 0) check("unexpected_flush", 32'(bus.flush_req), 0);
                else check("flush_pc", bus.flush_pc, exp_q[0].fpc);
                check("flush_ready_low", 32'(bus.excp_ready), 0);
                check("flush_strobes", 32'(strb), 0);
                check("flush_trap_cnt", 32'(bus.trap_cnt), 32'(mon_cnt));
                flush_len++;
            end else if (!bus.excp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_update", 32'(strb), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("upd_strobes", 32'(strb), 32'(mon_e.strb));
                    check("upd_epc", bus.csr_epc_wdata, mon_e.epc);
                    check("upd_mcause", bus.csr_mcause_wdata, mon_e.mcause);
                    check("upd_mtval", bus.csr_mtval_wdata, mon_e.mtval);
                    check("upd_trap_cnt", 32'(bus.trap_cnt), 32'(mon_e.cnt));
                    check("upd_flush_len", flush_len, mon_e.flen);
                    check("upd_flush_pc_zero", bus.flush_pc, 0);
                    mon_cnt = mon_e.cnt;
                end
                flush_len = 0;
            end else begin
                check("idle_flush_pc", bus.flush_pc, 0);
                check("idle_strobes", 32'(strb), 0);
                check("idle_wdata", bus.csr_epc_wdata | bus.csr_mcause_wdata | bus.csr_mtval_wdata, 0);
                check("idle_trap_cnt", 32'(bus.trap_cnt), 32'(mon_cnt));
                flush_len = 0;
            end
        end
    end

    // Drive one vector, push its expectation, then run the flush handshake.
    task automatic run_vec(input vec_t v);
        exp_t e;
        int   k;
        @(negedge clk);
        bus.dbg_req    = v.dbg;
        bus.excp_req   = v.excp;
        bus.irq_req    = v.irq;
        bus.mie_r      = v.mie;
        bus.mret_req   = v.mret;
        bus.excp_cause = v.cause;
        bus.excp_pc    = v.pc;
        bus.excp_tval  = v.tval;
        bus.irq_cause  = v.irqc;
        bus.mtvec_r    = v.mtvec;
        bus.mepc_r     = v.mepc;
        bus.flush_ack  = 1'b0;
        if (v.strb[1]) exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
        e = '{v.fpc, v.strb, v.epc, v.mcause, v.mtval, exp_cnt, v.dly + 1};
        exp_q.push_back(e);
        k = 0;
        @(negedge clk);
        while (!bus.flush_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("accept_latency", k, 0);
        drop_reqs();
        if (!bus.flush_req) begin
            exp_q.delete();
        end else begin
            repeat (v.dly) @(negedge clk);
            bus.flush_ack = 1'b1;
            @(negedge clk);
            bus.flush_ack = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int   k;
        int   t1;
        int   t2;
        exp_t e;

        //        dbg   excp  irq   mie   mret  cause         pc            tval          irqc   mtvec         mepc          dly  fpc           strb    epc           mcause        mtval
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2,        32'h100,      32'hDEAD,     4'h0, 32'h200,      32'h0,        2, 32'h200,      S_TRAP, 32'h100,      32'h2,        32'hDEAD};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h9,        32'h44,       32'h55,       4'h3, 32'h200,      32'h480,      1, 32'h800,      S_DBG,  32'h44,       32'h0,        32'h0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h1234,     32'h5555,     4'h7, 32'h301,      32'h0,        0, 32'h31C,      S_TRAP, 32'h1234,     32'h8000_0007, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        32'h0,        4'h0, 32'h0,        32'h480,      0, 32'h480,      S_MRET, 32'h0,        32'h0,        32'h0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hD,        32'h2000,     32'h1,        4'h0, 32'h301,      32'h0,        1, 32'h300,      S_TRAP, 32'h2000,     32'hD,        32'h1};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h3000,     32'h0,        4'hF, 32'hFFFF_FFF1, 32'h0,       0, 32'h2C,       S_TRAP, 32'h3000,     32'h8000_000F, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h3004,     32'h0,        4'h3, 32'h400,      32'h0,        3, 32'h400,      S_TRAP, 32'h3004,     32'h8000_0003, 32'h0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4,        32'h4000,     32'h44,       4'h2, 32'h500,      32'h900,      0, 32'h500,      S_TRAP, 32'h4000,     32'h4,        32'h44};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h4100,     32'h0,        4'h2, 32'h500,      32'h900,      0, 32'h900,      S_MRET, 32'h0,        32'h0,        32'h0};
        vecs[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h6,        32'h4200,     32'h66,       4'h9, 32'h601,      32'h900,      0, 32'h600,      S_TRAP, 32'h4200,     32'h6,        32'h66};

        drop_reqs();
        bus.excp_cause = '0;
        bus.excp_pc    = '0;
        bus.excp_tval  = '0;
        bus.irq_cause  = '0;
        bus.mie_r      = 1'b0;
        bus.mtvec_r    = '0;
        bus.mepc_r     = '0;
        bus.flush_ack  = 1'b0;
        rst_n   = 1'b0;
        exp_cnt = '0;
        mon_cnt = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(bus.excp_ready), 1);
        check("rst_flush_req", 32'(bus.flush_req), 0);
        check("rst_trap_cnt", 32'(bus.trap_cnt), 0);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Interrupt masked by mie_r: never accepted
        @(negedge clk);
        bus.irq_req   = 1'b1;
        bus.mie_r     = 1'b0;
        bus.irq_cause = 4'h7;
        bus.mtvec_r   = 32'h301;
        repeat (4) begin
            @(negedge clk);
            check("irq_masked_ready", 32'(bus.excp_ready), 1);
            check("irq_masked_flush", 32'(bus.flush_req), 0);
        end
        drop_reqs();

        // Held request with ack stuck high: accepts exactly 3 cycles apart
        @(negedge clk);
        bus.excp_req   = 1'b1;
        bus.excp_cause = 32'h5;
        bus.excp_pc    = 32'h600;
        bus.excp_tval  = 32'h77;
        bus.mtvec_r    = 32'h1000;
        bus.flush_ack  = 1'b1;
        for (int j = 0; j < 2; j++) begin
            exp_cnt = exp_cnt + 16'd1;
            e = '{32'h1000, S_TRAP, 32'h600, 32'h5, 32'h77, exp_cnt, 1};
            exp_q.push_back(e);
        end
        k = 0;
        @(negedge clk);
        while (!bus.flush_req && k < 10) begin @(negedge clk); k++; end
        t1 = cyc;
        @(negedge clk);
        k = 0;
        while (!bus.flush_req && k < 10) begin @(negedge clk); k++; end
        t2 = cyc;
        check("accept_spacing", t2 - t1, 3);
        drop_reqs();
        repeat (2) @(negedge clk);
        bus.flush_ack = 1'b0;

        // Reset while stuck in FLUSH without ack
        @(negedge clk);
        bus.excp_req   = 1'b1;
        bus.excp_cause = 32'h3;
        bus.excp_pc    = 32'h700;
        bus.excp_tval  = 32'h9;
        bus.mtvec_r    = 32'h200;
        e = '{32'h200, S_TRAP, 32'h700, 32'h3, 32'h9, exp_cnt, 1};
        exp_q.push_back(e);
        k = 0;
        @(negedge clk);
        while (!bus.flush_req && k < 10) begin @(negedge clk); k++; end
        @(negedge clk);
        check("pre_rst_flushing", 32'(bus.flush_req), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_cnt = '0;
        mon_cnt = '0;
        @(negedge clk);
        check("midrst_flush_req", 32'(bus.flush_req), 0);
        check("midrst_ready", 32'(bus.excp_ready), 1);
        check("midrst_trap_cnt", 32'(bus.trap_cnt), 0);
        check("midrst_strobes", 32'(strb), 0);
        @(negedge clk);
        check("midrst_held_req", 32'(bus.flush_req), 0);
        drop_reqs();
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_idle", 32'(bus.excp_ready), 1);
        end

        // Counter saturation: preload near the top, then trap, trap, mret
        @(posedge clk);
        #1;
        force dut.trap_cnt_q = 16'hFFFE;
        #1;
        release dut.trap_cnt_q;
        exp_cnt = 16'hFFFE;
        mon_cnt = 16'hFFFE;
        run_vec(vecs[0]);
        run_vec(vecs[2]);
        run_vec(vecs[3]);

        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 0);
        check("final_trap_cnt", 32'(bus.trap_cnt), 32'hFFFF);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 20000", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
